execute_stage: RTL and testbench
================================

# execute_stage

Parametrised RV32/RV64 execute stage, the successor to the fixed 32-bit decode-to-memory datapath slice. It holds the ID/EX and EX/MEM pipeline registers and resolves operand forwarding internally from the MEM and WB write-back tags. It adds a stall/flush handshake and an iterative multiply/divide path that holds the pipeline. It sits between the decode stage, which supplies register-file data and the immediate, and the memory stage.

## Interface
- XLEN, 32: datapath width; legal values are 32 or 64.
- REG_AW, 5: register-address width.
- clk in 1: clock; all state changes on the rising edge.
- rst in 1: asynchronous, active-high reset.
- id_valid in 1: the decode slot holds a real instruction.
- id_op in 5: operation code, from `exec_pkg`.
- id_alu_src in 1: 1 selects id_imm as operand B.
- id_reg_write, id_mem_write in 1 each: control bits passed down the pipe.
- id_result_src in 2: passed down the pipe.
- id_pc, id_pc_plus4, id_imm, id_rs1_data, id_rs2_data in XLEN each.
- id_rs1, id_rs2, id_rd in REG_AW each.
- flush_e in 1: load a bubble into ID/EX; aborts any multiply/divide in flight.
- mem_fwd_rd in REG_AW, mem_fwd_we in 1: forwarding tag for the MEM stage.
- wb_fwd_rd in REG_AW, wb_fwd_we in 1, wb_result in XLEN: forwarding tag and data for the WB stage.
- ex_busy out 1: combinational; upstream must hold its outputs and the PC.
- ex_zero out 1: combinational; (srcA − srcB) == 0.
- ex_pc_target out XLEN: combinational; PC_E + imm_E.
- mem_valid, mem_reg_write, mem_mem_write out 1 each.
- mem_result_src out 2.
- mem_rd out REG_AW.
- mem_alu_result, mem_write_data, mem_pc_plus4 out XLEN each.

## Operation
- **Reset.** Every ID/EX and EX/MEM field goes to 0, so mem_valid=0 and all mem_* outputs are 0. The FSM goes to IDLE, which gives ex_busy=0.
- **Forwarding, operand A** (operand B is identical, using rs2):
  - If mem_fwd_we && mem_fwd_rd!=0 && mem_fwd_rd==rs1_E, take mem_alu_result.
  - Else, if the same test holds against wb_fwd_rd/wb_fwd_we, take wb_result.
  - Else take the ID/EX register data.
  - MEM has priority over WB. Register x0 is never forwarded.
- **Operand B.** srcB = id_alu_src_E ? imm_E : forwarded rs2. mem_write_data always captures the forwarded rs2, never the immediate.
- **Single-cycle ops:** ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU.
  - Shift amount is srcB[log2(XLEN)-1:0].
  - SLT is a signed compare; SLTU is unsigned.
- **Multi-cycle ops:** MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
  - Computed by a radix-2 iterative unit working on magnitudes, with the sign corrected at the end.
  - MUL returns the low XLEN bits of the product. MULH/MULHSU/MULHU return the high XLEN bits.
- **Division corner cases:**
  - Divide by zero: quotient = all ones; remainder = dividend.
  - Signed overflow (−2^(XLEN−1) / −1): quotient = dividend; remainder = 0.
- **FSM, IDLE → RUN.** Taken when ID/EX holds a valid multiply/divide op. In this cycle ex_busy=1, and the forwarded operands are latched into the unit, because MEM/WB contents change while the FSM runs. Load cnt = XLEN−1.
- **FSM, RUN.** ex_busy=1 and one iteration per cycle. When cnt==0, move to DONE; otherwise decrement cnt.
- **FSM, DONE.** ex_busy=0. The result is written to EX/MEM at this edge, then the FSM returns to IDLE.
- **Pipeline while ex_busy=1:**
  - ID/EX holds its contents.
  - EX/MEM loads a bubble: mem_valid=0, mem_reg_write=0, mem_mem_write=0.
- **flush_e:**
  - flush_e=1 loads a bubble into ID/EX (valid=0, reg_write=0, mem_write=0). It has priority over the hold.
  - If the FSM is in RUN or DONE, it goes to IDLE and no result is written.
- **Invalid instructions.** An instruction with valid=0 propagates with mem_reg_write=0 and mem_mem_write=0.

## Timing
- **Single-cycle ops:** one cycle from the ID/EX capture edge to the EX/MEM capture edge. A back-to-back dependent instruction gets its operand from MEM forwarding with no stall.
- **Multi-cycle ops:**
  - Occupancy in EX is XLEN+2 cycles: 1 IDLE cycle, XLEN RUN cycles, 1 DONE cycle.
  - ex_busy is high for exactly XLEN+1 consecutive cycles.
  - This is 34 cycles when XLEN=32.
- **Combinational outputs.** ex_busy, ex_zero and ex_pc_target depend only on ID/EX state, FSM state and the forwarding inputs. None of them depend on flush_e.
- **Reset mid-operation.** Asserting rst during RUN clears everything asynchronously, and the result is discarded.

## Structure
- **`exec_pkg`:** holds the op-code enum (5 bits, 18 values), the FSM state enum {IDLE, RUN, DONE} and the forwarding-select enum {FWD_REG, FWD_WB, FWD_MEM}.
- **Sub-module `mdu_iter`:** parameter XLEN; inputs start, op, a, b, kill; outputs busy, done, result. It holds the FSM, the counter and the shift registers.
- **Top level:** holds the pipeline registers, the forwarding logic, the ALU and the PC-target adder.

## Test plan
- **Reset release:** mem_* are all 0 and ex_busy=0. Then issue ADD with rs1=5, rs2=7 → mem_alu_result=12 one cycle later.
- **Forwarding priority:** MEM tag rd=3 carries 0xAA and WB tag rd=3 carries 0xBB; EX instruction is ADD rs1=3, rs2=0 → mem_alu_result=0xAA. With the rd=0 tag instead → the register value is used.
- **DIV:**
  - −20/3 → quotient 0xFFFFFFFA (−6); REM −20,3 → 0xFFFFFFFE (−2).
  - ex_busy is high for 33 cycles and mem_valid=0 throughout.
- **Division corner cases:**
  - DIVU 9/0 → 0xFFFFFFFF; REMU 9/0 → 9.
  - DIV 0x80000000/−1 → 0x80000000; REM 0x80000000/−1 → 0.
- **MULH:**
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 2 → 1; MUL 0xFFFFFFFF × 2 → 0xFFFFFFFE.
- **Flush mid-divide:** flush_e in RUN cycle 10 → ex_busy=0 next cycle and no result appears. A following ADD then completes normally. Repeat with XLEN=64 and a DIVU → 66 EX cycles.

Source files
------------

// File: rtl/exec_pkg.sv
// exec_pkg: op codes, FSM/forwarding encodings and ID/EX control bundle for execute_stage
package exec_pkg;
  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } op_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [1:0] {FWD_REG, FWD_WB, FWD_MEM} fwd_t;
  typedef struct packed {
    logic       valid;
    op_t        op;
    logic       alu_src;
    logic       reg_write;
    logic       mem_write;
    logic [1:0] result_src;
  } ctrl_t;
  function automatic logic is_md(op_t op);
    return op >= OP_MUL;
  endfunction
endpackage

// File: rtl/mdu_iter.sv
// mdu_iter: radix-2 iterative multiply/divide on magnitudes with final sign correction
module mdu_iter import exec_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  op_t             op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN);
  state_t            r_state;
  op_t               r_op;
  logic              r_neg_q, r_neg_r;
  logic [CW-1:0]     r_cnt;
  logic [XLEN-1:0]   r_b, r_hi, r_lo;
  logic              w_na, w_nb;
  logic [XLEN-1:0]   w_ma, w_mb, w_q, w_r;
  logic [XLEN:0]     w_sum, w_sh, w_diff;
  logic [2*XLEN-1:0] w_p;
  assign w_na = a[XLEN-1] & (op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
  assign w_nb = b[XLEN-1] & (op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM});
  assign w_ma = w_na ? -a : a;
  assign w_mb = w_nb ? -b : b;
  // hi:lo is the product (shift-add) or remainder:quotient (restoring divide)
  assign w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  assign w_sh   = {r_hi, r_lo[XLEN-1]};
  assign w_diff = w_sh - {1'b0, r_b};
  assign w_p    = r_neg_q ? -{r_hi, r_lo} : {r_hi, r_lo};
  assign w_q    = r_neg_q ? -r_lo : r_lo;
  assign w_r    = r_neg_r ? -r_hi : r_hi;
  assign result = r_op == OP_MUL ? w_p[XLEN-1:0] : r_op < OP_DIV ? w_p[2*XLEN-1:XLEN] :
                  r_op inside {OP_DIV, OP_DIVU} ? w_q : w_r;
  assign busy   = (r_state == IDLE && start) || r_state == RUN;
  assign done   = r_state == DONE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_op    <= OP_ADD;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_cnt   <= '0;
      r_b     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= kill ? IDLE : r_state == IDLE ? (start ? RUN : IDLE) :
                 r_state == RUN ? (r_cnt == '0 ? DONE : RUN) : IDLE;
      if (r_state == IDLE && start) begin
        r_op    <= op;
        r_b     <= w_mb;
        r_neg_q <= (w_na ^ w_nb) && b != '0;
        r_neg_r <= w_na;
        r_cnt   <= CW'(XLEN - 1);
        r_hi    <= '0;
        r_lo    <= w_ma;
      end else if (r_state == RUN) begin
        r_cnt <= r_cnt - 1'b1;
        if (r_op >= OP_DIV) begin
          r_hi <= w_diff[XLEN] ? w_sh[XLEN-1:0] : w_diff[XLEN-1:0];
          r_lo <= {r_lo[XLEN-2:0], ~w_diff[XLEN]};
        end else begin
          r_hi <= w_sum[XLEN:1];
          r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
        end
      end
    end
  end
endmodule

// File: rtl/execute_stage.sv
// execute_stage: ID/EX + EX/MEM registers, operand forwarding, ALU and iterative mul/div
module execute_stage import exec_pkg::*; #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [4:0]        id_op,
  input  logic              id_alu_src,
  input  logic              id_reg_write,
  input  logic              id_mem_write,
  input  logic [1:0]        id_result_src,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_pc_plus4,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              flush_e,
  input  logic [REG_AW-1:0] mem_fwd_rd,
  input  logic              mem_fwd_we,
  input  logic [REG_AW-1:0] wb_fwd_rd,
  input  logic              wb_fwd_we,
  input  logic [XLEN-1:0]   wb_result,
  output logic              ex_busy,
  output logic              ex_zero,
  output logic [XLEN-1:0]   ex_pc_target,
  output logic              mem_valid,
  output logic              mem_reg_write,
  output logic              mem_mem_write,
  output logic [1:0]        mem_result_src,
  output logic [REG_AW-1:0] mem_rd,
  output logic [XLEN-1:0]   mem_alu_result,
  output logic [XLEN-1:0]   mem_write_data,
  output logic [XLEN-1:0]   mem_pc_plus4
);
  localparam int SW = $clog2(XLEN);
  ctrl_t             r_c;
  logic [XLEN-1:0]   r_pc, r_pc4, r_imm, r_rs1d, r_rs2d;
  logic [REG_AW-1:0] r_rs1, r_rs2, r_rd;
  fwd_t              w_fa, w_fb;
  logic [XLEN-1:0]   w_a, w_fwd_b, w_b, w_alu, w_md_res;
  logic              w_md_done, w_bub;
  assign w_fa = (mem_fwd_we && mem_fwd_rd != '0 && mem_fwd_rd == r_rs1) ? FWD_MEM :
                (wb_fwd_we && wb_fwd_rd != '0 && wb_fwd_rd == r_rs1) ? FWD_WB : FWD_REG;
  assign w_fb = (mem_fwd_we && mem_fwd_rd != '0 && mem_fwd_rd == r_rs2) ? FWD_MEM :
                (wb_fwd_we && wb_fwd_rd != '0 && wb_fwd_rd == r_rs2) ? FWD_WB : FWD_REG;
  assign w_a     = w_fa == FWD_MEM ? mem_alu_result : w_fa == FWD_WB ? wb_result : r_rs1d;
  assign w_fwd_b = w_fb == FWD_MEM ? mem_alu_result : w_fb == FWD_WB ? wb_result : r_rs2d;
  assign w_b     = r_c.alu_src ? r_imm : w_fwd_b;
  assign ex_zero      = w_a == w_b;
  assign ex_pc_target = r_pc + r_imm;
  // a flush that catches the result in DONE discards it
  assign w_bub = ex_busy || (w_md_done && flush_e);
  always_comb begin
    w_alu = '0;
    case (r_c.op)
      OP_ADD:  w_alu = w_a + w_b;
      OP_SUB:  w_alu = w_a - w_b;
      OP_AND:  w_alu = w_a & w_b;
      OP_OR:   w_alu = w_a | w_b;
      OP_XOR:  w_alu = w_a ^ w_b;
      OP_SLL:  w_alu = w_a << w_b[SW-1:0];
      OP_SRL:  w_alu = w_a >> w_b[SW-1:0];
      OP_SRA:  w_alu = $signed(w_a) >>> w_b[SW-1:0];
      OP_SLT:  w_alu = XLEN'($signed(w_a) < $signed(w_b));
      OP_SLTU: w_alu = XLEN'(w_a < w_b);
      default: w_alu = '0;
    endcase
  end
  mdu_iter #(.XLEN(XLEN)) u_mdu (
    .clk, .rst,
    .start (r_c.valid && is_md(r_c.op)),
    .kill  (flush_e),
    .op    (r_c.op),
    .a     (w_a),
    .b     (w_b),
    .busy  (ex_busy),
    .done  (w_md_done),
    .result(w_md_res)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_c    <= '0;
      r_pc   <= '0;
      r_pc4  <= '0;
      r_imm  <= '0;
      r_rs1d <= '0;
      r_rs2d <= '0;
      r_rs1  <= '0;
      r_rs2  <= '0;
      r_rd   <= '0;
    end else begin
      if (flush_e) r_c <= '0;
      else if (!ex_busy) r_c <= '{id_valid, op_t'(id_op), id_alu_src, id_reg_write, id_mem_write, id_result_src};
      if (!ex_busy) begin
        r_pc   <= id_pc;
        r_pc4  <= id_pc_plus4;
        r_imm  <= id_imm;
        r_rs1d <= id_rs1_data;
        r_rs2d <= id_rs2_data;
        r_rs1  <= id_rs1;
        r_rs2  <= id_rs2;
        r_rd   <= id_rd;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_valid      <= 1'b0;
      mem_reg_write  <= 1'b0;
      mem_mem_write  <= 1'b0;
      mem_result_src <= '0;
      mem_rd         <= '0;
      mem_alu_result <= '0;
      mem_write_data <= '0;
      mem_pc_plus4   <= '0;
    end else begin
      mem_valid      <= r_c.valid & ~w_bub;
      mem_reg_write  <= r_c.valid & r_c.reg_write & ~w_bub;
      mem_mem_write  <= r_c.valid & r_c.mem_write & ~w_bub;
      mem_result_src <= r_c.result_src;
      mem_rd         <= r_rd;
      mem_alu_result <= w_md_done ? w_md_res : w_alu;
      mem_write_data <= w_fwd_b;
      mem_pc_plus4   <= r_pc4;
    end
  end
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: randomized and directed checks of execute_stage against a behavioural model
module tb_execute_stage;
  import exec_pkg::*;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 0, id_alu_src = 0, id_reg_write = 0, id_mem_write = 0, flush_e = 0;
  logic [1:0]  id_result_src = 0;
  logic [4:0]  id_op = 0, id_rs1 = 0, id_rs2 = 0, id_rd = 0;
  logic [63:0] id_pc = 0, id_pc4 = 0, id_imm = 0, id_a = 0, id_b = 0, wb_result = 0;
  logic [4:0]  mem_fwd_rd = 0, wb_fwd_rd = 0;
  logic        mem_fwd_we = 0, wb_fwd_we = 0;
  logic        busy, zero, mv, mrw, mmw;
  logic [1:0]  mrs;
  logic [4:0]  mrd;
  logic [31:0] pct, mres, mwd, mpc4;
  logic        busy64, zero64, mv64, mrw64, mmw64;
  logic [1:0]  mrs64;
  logic [4:0]  mrd64;
  logic [63:0] pct64, mres64, mwd64, mpc64;
  int checks = 0, fails = 0;

  always #5 clk = ~clk;

  execute_stage #(.XLEN(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_op(id_op), .id_alu_src(id_alu_src),
    .id_reg_write(id_reg_write), .id_mem_write(id_mem_write), .id_result_src(id_result_src),
    .id_pc(id_pc[31:0]), .id_pc_plus4(id_pc4[31:0]), .id_imm(id_imm[31:0]),
    .id_rs1_data(id_a[31:0]), .id_rs2_data(id_b[31:0]), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .flush_e(flush_e), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_we(mem_fwd_we), .wb_fwd_rd(wb_fwd_rd),
    .wb_fwd_we(wb_fwd_we), .wb_result(wb_result[31:0]), .ex_busy(busy), .ex_zero(zero),
    .ex_pc_target(pct), .mem_valid(mv), .mem_reg_write(mrw), .mem_mem_write(mmw),
    .mem_result_src(mrs), .mem_rd(mrd), .mem_alu_result(mres), .mem_write_data(mwd),
    .mem_pc_plus4(mpc4));

  execute_stage #(.XLEN(64), .REG_AW(5)) dut64 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_op(id_op), .id_alu_src(id_alu_src),
    .id_reg_write(id_reg_write), .id_mem_write(id_mem_write), .id_result_src(id_result_src),
    .id_pc(id_pc), .id_pc_plus4(id_pc4), .id_imm(id_imm), .id_rs1_data(id_a), .id_rs2_data(id_b),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .flush_e(flush_e), .mem_fwd_rd(mem_fwd_rd),
    .mem_fwd_we(mem_fwd_we), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_we(wb_fwd_we), .wb_result(wb_result),
    .ex_busy(busy64), .ex_zero(zero64), .ex_pc_target(pct64), .mem_valid(mv64),
    .mem_reg_write(mrw64), .mem_mem_write(mmw64), .mem_result_src(mrs64), .mem_rd(mrd64),
    .mem_alu_result(mres64), .mem_write_data(mwd64), .mem_pc_plus4(mpc64));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input op_t op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, sp;
    logic [63:0] up;
    logic ovf;
    sa  = $signed(a);
    sb  = $signed(b);
    ovf = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    case (op)
      OP_ADD:    return a + b;
      OP_SUB:    return a - b;
      OP_AND:    return a & b;
      OP_OR:     return a | b;
      OP_XOR:    return a ^ b;
      OP_SLL:    return a << b[4:0];
      OP_SRL:    return a >> b[4:0];
      OP_SRA:    begin sp = sa >>> b[4:0]; return sp[31:0]; end
      OP_SLT:    return {31'b0, sa < sb};
      OP_SLTU:   return {31'b0, a < b};
      OP_MUL:    begin sp = sa * sb; return sp[31:0]; end
      OP_MULH:   begin sp = sa * sb; return sp[63:32]; end
      OP_MULHSU: begin sp = sa * $signed({32'b0, b}); return sp[63:32]; end
      OP_MULHU:  begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
      OP_DIV:    begin sp = sa / (b == 0 ? 64'sd1 : sb); return b == 0 ? 32'hFFFF_FFFF : ovf ? a : sp[31:0]; end
      OP_DIVU:   return b == 0 ? 32'hFFFF_FFFF : a / b;
      OP_REM:    begin sp = sa % (b == 0 ? 64'sd1 : sb); return b == 0 ? a : ovf ? 32'h0 : sp[31:0]; end
      OP_REMU:   return b == 0 ? a : a % b;
      default:   return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] rnd();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  task automatic drive(input op_t op, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [63:0] a, input logic [63:0] b, input logic src, input logic [63:0] imm);
    id_valid = 1; id_op = op; id_rs1 = rs1; id_rs2 = rs2; id_a = a; id_b = b;
    id_alu_src = src; id_imm = imm; id_reg_write = 1; id_mem_write = 1'($urandom);
    id_result_src = 2'($urandom); id_rd = 5'($urandom_range(1, 31));
    id_pc = {$urandom, $urandom}; id_pc4 = id_pc + 4;
  endtask

  task automatic exec(input op_t op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp, input string tag);
    int lat = 0, nb = 0;
    logic md;
    logic [4:0] rd;
    logic [31:0] e_pct;
    logic mw;
    logic [1:0] rs;
    md = op >= OP_MUL;
    drive(op, 5'd1, 5'd2, {32'b0, a}, {32'b0, b}, 1'b0, {$urandom, $urandom});
    rd = id_rd; mw = id_mem_write; rs = id_result_src; e_pct = id_pc[31:0] + id_imm[31:0];
    @(posedge clk); @(negedge clk);
    id_valid = 0;
    chk({tag, "_pct"}, pct, e_pct);
    chk({tag, "_zero"}, zero, a == b);
    while (!mv && lat < 200) begin
      nb += busy;
      @(posedge clk); lat++; @(negedge clk);
    end
    chk({tag, "_lat"}, lat, md ? 34 : 1);
    chk({tag, "_busy"}, nb, md ? 33 : 0);
    chk({tag, "_res"}, mres, exp);
    chk({tag, "_wd"}, mwd, b);
    chk({tag, "_ctl"}, {mrw, mmw, mrs, mrd}, {1'b1, mw, rs, rd});
  endtask

  task automatic exec64(input op_t op, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input string tag);
    int lat = 0, nb = 0;
    drive(op, 5'd1, 5'd2, a, b, 1'b0, 64'h0);
    @(posedge clk); @(negedge clk);
    id_valid = 0;
    while (!mv64 && lat < 300) begin
      nb += busy64;
      @(posedge clk); lat++; @(negedge clk);
    end
    chk({tag, "_lat"}, lat, 66);
    chk({tag, "_busy"}, nb, 65);
    chk({tag, "_res"}, mres64, exp);
  endtask

  task automatic fwd_case(input logic [4:0] mrd_t, input logic mwe, input logic [4:0] wrd_t, input logic wwe,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic src,
                          input logic [31:0] exp_r, input logic [31:0] exp_wd, input string tag);
    drive(OP_ADD, 5'd1, 5'd2, 64'hAA, 64'h0, 1'b0, 64'h0);
    @(posedge clk); @(negedge clk);
    drive(OP_ADD, rs1, rs2, 64'h11, 64'h22, src, 64'h5);
    mem_fwd_rd = mrd_t; mem_fwd_we = mwe; wb_fwd_rd = wrd_t; wb_fwd_we = wwe; wb_result = 64'hBB;
    @(posedge clk); @(negedge clk);
    id_valid = 0;
    @(posedge clk); @(negedge clk);
    chk({tag, "_res"}, mres, exp_r);
    chk({tag, "_wd"}, mwd, exp_wd);
    mem_fwd_we = 0; wb_fwd_we = 0;
  endtask

  initial begin
    logic any;
    logic [63:0] a64, b64;
    op_t op;
    logic [31:0] ra, rb;
    repeat (3) @(negedge clk);
    rst = 0;
    chk("rst_mem", {mv, mrw, mmw, mrs, mrd}, 0);
    chk("rst_data", {mres, mwd, mpc4}, 0);
    chk("rst_busy", {busy, busy64, mv64}, 0);
    @(negedge clk);
    exec(OP_ADD, 32'd5, 32'd7, 32'd12, "add_5_7");
    fwd_case(5'd3, 1, 5'd3, 1, 5'd3, 5'd0, 0, 32'hCC, 32'h22, "fwd_mem_pri");
    fwd_case(5'd0, 1, 5'd0, 1, 5'd0, 5'd0, 0, 32'h33, 32'h22, "fwd_x0");
    fwd_case(5'd0, 1, 5'd0, 1, 5'd3, 5'd0, 0, 32'h33, 32'h22, "fwd_tag0");
    fwd_case(5'd3, 0, 5'd3, 1, 5'd3, 5'd0, 0, 32'hDD, 32'h22, "fwd_wb");
    fwd_case(5'd4, 1, 5'd3, 1, 5'd3, 5'd4, 1, 32'hC0, 32'hAA, "fwd_imm_wd");
    fwd_case(5'd4, 1, 5'd4, 1, 5'd1, 5'd4, 0, 32'hBB, 32'hAA, "fwd_rs2");
    exec(OP_DIV, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, "div_m20_3");
    exec(OP_REM, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, "rem_m20_3");
    exec(OP_DIVU, 32'd9, 32'd0, 32'hFFFF_FFFF, "divu_by0");
    exec(OP_REMU, 32'd9, 32'd0, 32'd9, "remu_by0");
    exec(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
    exec(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, "rem_ovf");
    exec(OP_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_min");
    exec(OP_MULHU, 32'hFFFF_FFFF, 32'd2, 32'd1, "mulhu");
    exec(OP_MUL, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, "mul");
    for (int i = 0; i < 60; i++) begin
      op = op_t'($urandom_range(0, 17));
      ra = rnd();
      rb = rnd();
      exec(op, ra, rb, model(op, ra, rb), $sformatf("rnd%0d_%s", i, op.name()));
    end
    drive(OP_DIV, 5'd1, 5'd2, 64'd100, 64'd7, 1'b0, 64'h0);
    @(posedge clk); @(negedge clk);
    id_valid = 0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush_e = 1;
    chk("flush_busy_pre", busy, 1);
    @(posedge clk); @(negedge clk);
    flush_e = 0;
    chk("flush_busy_post", busy, 0);
    any = 0;
    repeat (40) begin @(posedge clk); @(negedge clk); any |= mv; end
    chk("flush_noresult", any, 0);
    exec(OP_ADD, 32'd3, 32'd4, 32'd7, "post_flush_add");
    drive(OP_DIVU, 5'd1, 5'd2, 64'd1000, 64'd3, 1'b0, 64'h0);
    @(posedge clk); @(negedge clk);
    id_valid = 0;
    repeat (5) @(posedge clk);
    #2 rst = 1;
    #1 chk("rstmid_clear", {busy, mv, mres}, 0);
    @(negedge clk); rst = 0;
    any = 0;
    repeat (40) begin @(posedge clk); @(negedge clk); any |= mv | busy; end
    chk("rstmid_discard", any, 0);
    a64 = {$urandom, $urandom};
    b64 = {32'b0, $urandom} | 64'h1;
    exec64(OP_DIVU, a64, b64, a64 / b64, "divu64");
    exec64(OP_REMU, a64, b64, a64 % b64, "remu64");
    exec64(OP_DIV, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, "div64_ovf");
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
